// File: rtl/pingpong_to_axi4.sv
// pingpong_to_axi4: streams a filled ping-pong bank out of a BRAM read port as AXI4-Stream beats.
// Optional macro PINGPONG_TO_AXI4_TLAST_EN marks the final beat of each bank with tlast.
module pingpong_to_axi4 #(
   parameter int ADDRBITS = 7,
   parameter int DATABITS = 16,
   parameter int MEMDEPTH = 128,
   parameter int RDLAT    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                finishb,
   input  logic [ADDRBITS:0]   lenb,
   output logic                readyb,
   output logic [ADDRBITS-1:0] addrb,
   output logic                enb,
   input  logic [DATABITS-1:0] doutb,
   output logic                doneb,
   output logic [DATABITS-1:0] m_axis_data_tdata,
   output logic                m_axis_data_tvalid,
   input  logic                m_axis_data_tready,
   output logic                m_axis_data_tlast
);

   localparam int FDEPTH = RDLAT + 2;
   localparam int PTRW   = $clog2(FDEPTH);
   localparam int CNTW   = $clog2(FDEPTH + 1);
   localparam logic [ADDRBITS:0] MAXLEN = (ADDRBITS+1)'(MEMDEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [ADDRBITS:0]   len_r;
   logic [ADDRBITS:0]   addr_r;
   logic [RDLAT-1:0]    pipe_r;
   logic [DATABITS-1:0] fifo_r [FDEPTH];
   logic [PTRW-1:0]     wr_ptr_r;
   logic [PTRW-1:0]     rd_ptr_r;
   logic [CNTW-1:0]     cnt_r;
   logic [CNTW-1:0]     inflight_s;
   logic [CNTW:0]       occ_s;
   logic                issue_s;
   logic                push_s;
   logic                pop_s;
   logic                start_s;

   function automatic logic [CNTW-1:0] count_ones(input logic [RDLAT-1:0] v);
      logic [CNTW-1:0] n;
      n = '0;
      for (int i = 0; i < RDLAT; i++) begin
         n = n + CNTW'(v[i]);
      end
      return n;
   endfunction

   function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
      if (p == PTRW'(FDEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTRW'(1);
      end
   endfunction

   // Read issue throttle: reads in flight plus buffered words never exceed the skid depth
   always_comb begin
      inflight_s = count_ones(pipe_r);
      occ_s      = {1'b0, inflight_s} + {1'b0, cnt_r};
      start_s    = (state_r == IDLE) && finishb;
      issue_s    = (state_r == READ) && (addr_r < len_r) && (occ_s < (CNTW+1)'(FDEPTH));
      push_s     = pipe_r[RDLAT-1];
      pop_s      = (cnt_r != '0) && m_axis_data_tready;
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (finishb) state_s = READ;
            else         state_s = IDLE;
         end
         READ: begin
            if (len_r == '0)          state_s = DONE;
            else if (addr_r == len_r) state_s = DRAIN;
            else                      state_s = READ;
         end
         DRAIN: begin
            if ((cnt_r == '0) && (pipe_r == '0)) state_s = DONE;
            else                                 state_s = DRAIN;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, latched length, read address and read-latency tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         len_r   <= '0;
         addr_r  <= '0;
         pipe_r  <= '0;
      end else begin
         state_r <= state_s;
         if (start_s) begin
            len_r  <= (lenb > MAXLEN) ? MAXLEN : lenb;
            addr_r <= '0;
            pipe_r <= '0;
         end else begin
            pipe_r <= (pipe_r << 1'b1) | RDLAT'(issue_s);
            if (issue_s) addr_r <= addr_r + (ADDRBITS+1)'(1);
         end
      end
   end

   // Skid FIFO capturing read data as it returns from the bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FDEPTH; i++) fifo_r[i] <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (push_s) begin
            fifo_r[wr_ptr_r] <= doutb;
            wr_ptr_r         <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
         cnt_r <= cnt_r + CNTW'(push_s) - CNTW'(pop_s);
      end
   end

`ifdef PINGPONG_TO_AXI4_TLAST_EN
   logic [ADDRBITS:0] beat_r;

   // Beats leave in address order, so the accepted-beat count is the head's address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_r <= '0;
      end else if (start_s) begin
         beat_r <= '0;
      end else if (pop_s) begin
         beat_r <= beat_r + (ADDRBITS+1)'(1);
      end
   end

   assign m_axis_data_tlast = (cnt_r != '0) && (beat_r == len_r - (ADDRBITS+1)'(1));
`else
   assign m_axis_data_tlast = 1'b0;
`endif

   assign readyb             = (state_r == IDLE);
   assign doneb              = (state_r == DONE);
   assign enb                = issue_s;
   assign addrb              = addr_r[ADDRBITS-1:0];
   assign m_axis_data_tvalid = (cnt_r != '0);
   assign m_axis_data_tdata  = fifo_r[rd_ptr_r];

endmodule
